// File: rtl/msd_pkg.sv
// Shared constants and types for the moving-window-sum decoder.
package msd_pkg;

    localparam int unsigned DATA_W_DEF = 24;
    localparam int unsigned WINDOW_DEF = 64;
    localparam int unsigned SAMPLE_W   = DATA_W_DEF;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

endpackage

// File: rtl/history_ring.sv
// Circular history of decoded sample pairs; owns the shared write/read pointer.
module history_ring
    import msd_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned WINDOW = WINDOW_DEF,
    parameter int unsigned PTR_W  = $clog2(WINDOW)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                we_i,
    input  logic [2*DATA_W-1:0] wdata_i,
    output logic [2*DATA_W-1:0] rdata_c_o
);

    logic [2*DATA_W-1:0] mem_q [WINDOW];
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (we_i) begin
            ptr_d = (ptr_q == PTR_W'(WINDOW - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Contents are left uncleared on reset; the warm-up phase masks them.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[ptr_q] <= wdata_i;
        end
    end

    // Read-before-write: the pre-edge contents at ptr are what the adders see.
    assign rdata_c_o = mem_q[ptr_q];

endmodule

// File: rtl/moving_sum_decoder.sv
// Inverts the N-sample running sum: x[n] = (y[n] - y[n-1]) + x[n-N], per channel.
module moving_sum_decoder
    import msd_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned WINDOW = WINDOW_DEF,
    parameter int unsigned PTR_W  = $clog2(WINDOW)
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              read_ready,
    output logic              read,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    input  logic              write_ready,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              primed
);

    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PAIR_W = 2 * DATA_W;

    state_t             state_q;
    logic [CNT_W-1:0]   count_q;
    logic               primed_q;
    logic               out_valid_q;
    logic [DATA_W-1:0]  prev_l_q;
    logic [DATA_W-1:0]  prev_r_q;
    logic [DATA_W-1:0]  wd_l_q;
    logic [DATA_W-1:0]  wd_r_q;

    logic               accept_c;
    logic               drain_c;
    logic [PAIR_W-1:0]  hist_c;
    logic [DATA_W-1:0]  old_l_c;
    logic [DATA_W-1:0]  old_r_c;
    logic [DATA_W-1:0]  x_l_c;
    logic [DATA_W-1:0]  x_r_c;

    assign read = !out_valid_q || write_ready;

    // Modular arithmetic throughout: wrap is what makes the inverse exact.
    always_comb begin
        accept_c = read_ready && read;
        drain_c  = out_valid_q && write_ready;
        old_l_c  = '0;
        old_r_c  = '0;
        if (state_q == RUN) begin
            old_l_c = hist_c[PAIR_W-1:DATA_W];
            old_r_c = hist_c[DATA_W-1:0];
        end
        x_l_c = (readdata_left  - prev_l_q) + old_l_c;
        x_r_c = (readdata_right - prev_r_q) + old_r_c;
    end

    history_ring #(
        .DATA_W (DATA_W),
        .WINDOW (WINDOW),
        .PTR_W  (PTR_W)
    ) u_ring (
        .clk_i     (CLOCK_50),
        .rst_n_i   (reset_n),
        .we_i      (accept_c),
        .wdata_i   ({x_l_c, x_r_c}),
        .rdata_c_o (hist_c)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q     <= WARMUP;
            count_q     <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            prev_l_q    <= '0;
            prev_r_q    <= '0;
            wd_l_q      <= '0;
            wd_r_q      <= '0;
        end else if (accept_c) begin
            out_valid_q <= 1'b1;
            wd_l_q      <= x_l_c;
            wd_r_q      <= x_r_c;
            prev_l_q    <= readdata_left;
            prev_r_q    <= readdata_right;
            // Leave warm-up on the accept that completes the first full window.
            if (state_q == WARMUP) begin
                count_q <= count_q + CNT_W'(1);
                if (count_q == CNT_W'(WINDOW - 1)) begin
                    state_q  <= RUN;
                    primed_q <= 1'b1;
                end
            end
        end else if (drain_c) begin
            out_valid_q <= 1'b0;
        end
    end

    assign write           = out_valid_q;
    assign writedata_left  = wd_l_q;
    assign writedata_right = wd_r_q;
    assign primed          = primed_q;

endmodule

// File: doc/moving_sum_decoder.md
Name: moving_sum_decoder

Overview:
- Receive-side inverse of the transmit-side moving-window-sum (comb + integrator) filter.
- Recovers the original sample stream from the N-sample running-sum stream: x[n] = (y[n] - y[n-1]) + x[n-N].
- Sits between the audio core's read interface and its write interface, with independent left and right channels.
- Uses the same read_ready/read and write_ready/write handshake as the rest of the audio path.

Parameters:
- DATA_W, 24: sample width, two's complement.
- WINDOW, 64: window length N; must match the encoder. Power of two, at least 2.
- PTR_W, 6: log2(WINDOW).

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- read_ready  in  1  audio core has a new running-sum sample pair.
- read  out  1  block accepts the current readdata pair this cycle.
- readdata_left  in  DATA_W  running-sum sample, left.
- readdata_right  in  DATA_W  running-sum sample, right.
- write_ready  in  1  audio core can take an output pair.
- write  out  1  writedata pair is valid.
- writedata_left  out  DATA_W  decoded sample, left.
- writedata_right  out  DATA_W  decoded sample, right.
- primed  out  1  WINDOW samples have been accepted since reset (history is real data).

Behaviour:
- Clock and reset: one clock, CLOCK_50. reset_n is synchronous and active-low.
- Values while reset_n=0:
  - write=0, writedata_*=0, primed=0.
  - prev_y_* = 0, ptr = 0, fill count = 0, out_valid = 0.
  - History RAM is not cleared; stale contents are masked by WARMUP.
- Handshake:
  - read = !out_valid || write_ready (combinational).
  - accept = read_ready && read.
  - write = out_valid.
  - drain = write && write_ready.
- Output register:
  - On accept: load new outputs, out_valid <= 1.
  - On drain without accept: out_valid <= 0.
  - Accept and drain in the same cycle: out_valid stays 1 and takes the new data. No bubble, no loss.
- Latency: one cycle. A pair accepted at edge k appears on writedata_* with write=1 after edge k.
- Per-channel datapath, on accept:
  - d = readdata - prev_y, modulo 2^DATA_W.
  - old = history[ptr] if in RUN, else 0.
  - x = d + old, modulo 2^DATA_W. No saturation; wrap is required for an exact inverse.
  - history[ptr] <= x; prev_y <= readdata; writedata <= x.
- Pointer: ptr increments on each accept and wraps from WINDOW-1 to 0. It never moves without an accept.
- History read is read-before-write at the same address in the same cycle. The old value is used.
- State machine:
  - WARMUP: fill count increments per accept. The transition to RUN is taken on the accept that makes count = WINDOW.
  - RUN: count frozen; primed=1.
  - Only reset returns the block to WARMUP.
- Ignored inputs: readdata is ignored whenever accept=0.
- Reset mid-stream: the next accepted sample decodes exactly as the first sample after power-up.
- Channel independence: left and right share ptr, state and handshake; their data paths are independent.

Decomposition:
- Shared package msd_pkg:
  - Constants DATA_W_DEF=24, WINDOW_DEF=64.
  - Typedef sample_t = logic signed [DATA_W-1:0].
  - Typedef enum state_t {WARMUP, RUN}.
- Sub-module history_ring:
  - WINDOW x (2*DATA_W) register array with combinational read at ptr and write-enable on accept.
  - Owns ptr and its wrap logic.
  - Left and right are packed in one word.
- Top level holds the handshake, prev_y registers, the FSM and the adders.

Test Plan:
All scenarios run with WINDOW=4, PTR_W=2, and write_ready=1 unless stated.
1. Reset: reset_n=0 for 2 cycles, read_ready=0 -> write=0, writedata_*=0, primed=0, read=1.
2. Impulse: left y = 5,5,5,5,0,0,0 -> x = 5,0,0,0,0,0,0. Right fed -7,-7,-7,-7,0,0 -> x = -7,0,0,0,0,0. primed rises on the accept of the 4th sample.
3. Step: y = 3,6,9,12,12,12,12 -> x = 3,3,3,3,3,3,3. Each output appears one cycle after its accept.
4. Wrap arithmetic: y = 24'h7FFFFF, 24'h800000 -> x = 24'h7FFFFF, 24'h000001. No saturation.
5. Backpressure:
   - Hold write_ready=0 after one accept -> read=0 and writedata is held while readdata changes.
   - Raise write_ready while read_ready=1 -> same-cycle drain and accept, write stays 1.
   - The full stream from scenario 3 is reproduced with no loss or duplication.
6. Reset mid-stream: run scenario 3 for 6 samples, pulse reset_n=0 for 1 cycle, then run scenario 2 -> output is 5,0,0,0,... Stale history has no effect; primed drops and re-rises after 4 accepts.
